// File: rtl/cacheevict_pkg.sv
// Shared constants and FSM type for the victim write-back buffer.
// Derived values below describe the default configuration.
package cacheevict_pkg;

  localparam int unsigned DefDepth     = 4;
  localparam int unsigned DefPaBits    = 32;
  localparam int unsigned DefLineLen   = 512;
  localparam int unsigned DefBeatW     = 64;
  localparam int unsigned DefOffsetLen = 6;

  localparam int unsigned BEATS       = DefLineLen / DefBeatW;
  localparam int unsigned LOGBEATS    = $clog2(BEATS);
  localparam int unsigned LINEADRLEN  = DefPaBits - DefOffsetLen;
  localparam int unsigned BEATBYTEOFF = $clog2(DefBeatW / 8);

  typedef enum logic {IDLE, BURST} burst_state_e;

endpackage

// File: rtl/cache_evict_burst.sv
// Write-back burst sequencer: walks the beats of the head line.
// It pops the head on the last-beat handshake.
module cache_evict_burst
  import cacheevict_pkg::*;
#(
  parameter int unsigned Beats = BEATS,
  localparam int unsigned LogBeats = $clog2(Beats)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                avail_i,     // occupancy nonzero
  input  logic                more_i,      // occupancy nonzero after a pop this cycle
  input  logic                bus_ready_i,
  output logic                bus_valid_o,
  output logic [LogBeats-1:0] beat_o,
  output logic                first_o,
  output logic                last_o,
  output logic                pop_o
);

  burst_state_e        state_q, state_d;
  logic [LogBeats-1:0] beat_q, beat_d;
  logic                at_last;

  assign at_last = (beat_q == LogBeats'(Beats - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    bus_valid_o = 1'b0;
    pop_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        beat_d = '0;
        if (avail_i) state_d = BURST;
      end
      BURST: begin
        bus_valid_o = 1'b1;
        if (bus_ready_i) begin
          if (at_last) begin
            pop_o   = 1'b1;
            beat_d  = '0;
            state_d = more_i ? BURST : IDLE;
          end else begin
            beat_d = beat_q + LogBeats'(1);
          end
        end
      end
    endcase
  end

  assign beat_o  = beat_q;
  assign first_o = bus_valid_o && (beat_q == '0);
  assign last_o  = bus_valid_o && at_last;

endmodule

// File: rtl/cache_evict_buffer.sv
// Victim-line FIFO: captures dirty lines and writes them back as beat bursts.
// A combinational lookup flags refills whose line is still pending.
module cache_evict_buffer
  import cacheevict_pkg::*;
#(
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned PA_BITS   = DefPaBits,
  parameter int unsigned LINELEN   = DefLineLen,
  parameter int unsigned BEATW     = DefBeatW,
  parameter int unsigned OFFSETLEN = DefOffsetLen,
  localparam int unsigned LineAdrLen = PA_BITS - OFFSETLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  EvictValid,
  output logic                  EvictReady,
  input  logic [LineAdrLen-1:0] EvictAdr,
  input  logic [LINELEN-1:0]    EvictLine,
  input  logic [LineAdrLen-1:0] LookupAdr,
  output logic                  LookupHit,
  output logic                  BusValid,
  input  logic                  BusReady,
  output logic [PA_BITS-1:0]    BusAdr,
  output logic [BEATW-1:0]      BusData,
  output logic                  BusFirst,
  output logic                  BusLast,
  output logic                  Empty
);

  localparam int unsigned Beats       = LINELEN / BEATW;
  localparam int unsigned LogBeats    = $clog2(Beats);
  localparam int unsigned BeatByteOff = $clog2(BEATW / 8);
  localparam int unsigned PtrW        = $clog2(DEPTH);
  localparam int unsigned CntW        = PtrW + 1;

  logic [LineAdrLen-1:0] adr_q  [DEPTH];
  logic [LINELEN-1:0]    line_q [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [LogBeats-1:0]   beat;
  logic                  push, pop, more;

  assign EvictReady = (count_q != CntW'(DEPTH));
  assign Empty      = (count_q == '0);
  assign push       = EvictValid && EvictReady;
  // Occupancy after a pop stays nonzero if another entry waits or one arrives now.
  assign more       = (count_q > CntW'(1)) || push;

  cache_evict_burst #(
    .Beats(Beats)
  ) u_burst (
    .clk        (clk),
    .reset      (reset),
    .avail_i    (!Empty),
    .more_i     (more),
    .bus_ready_i(BusReady),
    .bus_valid_o(BusValid),
    .beat_o     (beat),
    .first_o    (BusFirst),
    .last_o     (BusLast),
    .pop_o      (pop)
  );

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PtrW'(1);
    end
    if (push && !pop) count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[tail_q]  <= EvictAdr;
      line_q[tail_q] <= EvictLine;
    end
  end

  always_comb begin
    LookupHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (adr_q[i] == LookupAdr)) LookupHit = 1'b1;
    end
  end

  assign BusData = line_q[head_q][int'(beat) * BEATW +: BEATW];
  assign BusAdr  = {adr_q[head_q], beat, {BeatByteOff{1'b0}}};

endmodule

// File: tb/tb_cache_evict_buffer.sv
// Randomised and directed bench for cache_evict_buffer against a queue-based model.
module tb_cache_evict_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned BEATS = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         EvictValid;
  logic         EvictReady;
  logic [25:0]  EvictAdr;
  logic [511:0] EvictLine;
  logic [25:0]  LookupAdr;
  logic         LookupHit;
  logic         BusValid;
  logic         BusReady;
  logic [31:0]  BusAdr;
  logic [63:0]  BusData;
  logic         BusFirst;
  logic         BusLast;
  logic         Empty;

  cache_evict_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .EvictValid(EvictValid),
    .EvictReady(EvictReady),
    .EvictAdr  (EvictAdr),
    .EvictLine (EvictLine),
    .LookupAdr (LookupAdr),
    .LookupHit (LookupHit),
    .BusValid  (BusValid),
    .BusReady  (BusReady),
    .BusAdr    (BusAdr),
    .BusData   (BusData),
    .BusFirst  (BusFirst),
    .BusLast   (BusLast),
    .Empty     (Empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0]  adr;
    logic [511:0] line;
  } entry_t;

  // Model: pending lines in push order, whether a burst is on the bus, and its beat.
  entry_t q[$];
  bit     active;
  int     k;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_outputs();
    bit          hit;
    logic [31:0] exp_adr;
    hit = 1'b0;
    foreach (q[i]) if (q[i].adr == LookupAdr) hit = 1'b1;
    check_eq("evict_ready", EvictReady, q.size() < DEPTH);
    check_eq("empty", Empty, q.size() == 0);
    check_eq("bus_valid", BusValid, active);
    check_eq("lookup_hit", LookupHit, hit);
    check_eq("bus_first", BusFirst, active && k == 0);
    check_eq("bus_last", BusLast, active && k == BEATS - 1);
    if (active && q.size() != 0) begin
      exp_adr = {q[0].adr, 6'(k * 8)};
      check_eq("bus_adr", BusAdr, exp_adr);
      check_eq("bus_data", BusData, q[0].line[k*64 +: 64]);
    end
  endtask

  task automatic step(input bit ev, input logic [25:0] adr, input logic [511:0] line,
                      input bit rdy, input logic [25:0] la);
    int sz;
    bit pushed;
    entry_t e;
    @(negedge clk);
    EvictValid = ev;
    EvictAdr   = adr;
    EvictLine  = line;
    BusReady   = rdy;
    LookupAdr  = la;
    #1;
    check_outputs();
    @(posedge clk);
    sz     = q.size();
    pushed = ev && (sz < DEPTH);
    if (active && rdy) begin
      if (k == BEATS - 1) begin
        void'(q.pop_front());
        k      = 0;
        active = (sz - 1 + int'(pushed)) > 0;
      end else begin
        k++;
      end
    end else if (!active) begin
      active = (sz != 0);
    end
    if (pushed) begin
      e.adr  = adr;
      e.line = line;
      q.push_back(e);
    end
  endtask

  task automatic idle(input bit rdy, input logic [25:0] la);
    step(1'b0, 26'h0, '0, rdy, la);
  endtask

  task automatic drain(input logic [25:0] la);
    int n;
    n = 0;
    while ((q.size() != 0 || active) && n < 200) begin
      idle(1'b1, la);
      n++;
    end
    check_eq("drain", q.size(), 0);
  endtask

  task automatic do_reset(input logic [25:0] la);
    @(negedge clk);
    EvictValid = 1'b0;
    LookupAdr  = la;
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_bus_valid", BusValid, 0);
    check_eq("rst_empty", Empty, 1);
    check_eq("rst_ready", EvictReady, 1);
    check_eq("rst_first", BusFirst, 0);
    check_eq("rst_last", BusLast, 0);
    check_eq("rst_lookup", LookupHit, 0);
    q.delete();
    active = 1'b0;
    k      = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [511:0] line;
    logic [25:0]  a;
    logic [31:0]  frozen_adr;
    logic [63:0]  frozen_data;
    int           n;

    EvictValid = 1'b0;
    EvictAdr   = '0;
    EvictLine  = '0;
    BusReady   = 1'b0;
    LookupAdr  = '0;
    active     = 1'b0;
    k          = 0;
    reset      = 1'b1;
    #1;
    check_eq("init_valid", BusValid, 0);
    check_eq("init_empty", Empty, 1);
    check_eq("init_ready", EvictReady, 1);
    #20;
    @(negedge clk);
    reset = 1'b0;

    // Single evict with beat-tagged data.
    for (int b = 0; b < 8; b++) line[b*64 +: 64] = 64'h1111_0000_0000_0000 | 64'(b);
    step(1'b1, 26'h3FF_FFFF, line, 1'b1, 26'h0);
    idle(1'b1, 26'h0);
    for (int b = 0; b < 8; b++) begin
      #1;
      check_eq("se_adr", BusAdr, 32'hFFFF_FFC0 + 32'(b * 8));
      check_eq("se_data", BusData, 64'h1111_0000_0000_0000 | 64'(b));
      check_eq("se_first", BusFirst, b == 0);
      check_eq("se_last", BusLast, b == 7);
      idle(1'b1, 26'h0);
    end
    #1;
    check_eq("se_empty", Empty, 1);

    // Backpressure at beat 3.
    step(1'b1, 26'h0ABC_DEF, rand_line(), 1'b1, 26'h0);
    n = 0;
    while (!(active && k == 3) && n < 20) begin idle(1'b1, 26'h0); n++; end
    #1;
    frozen_adr  = BusAdr;
    frozen_data = BusData;
    check_eq("bp_adr3", frozen_adr, {26'h0ABC_DEF, 6'h18});
    for (int i = 0; i < 5; i++) idle(1'b0, 26'h0);
    #1;
    check_eq("bp_held_adr", BusAdr, frozen_adr);
    check_eq("bp_held_data", BusData, frozen_data);
    idle(1'b1, 26'h0);
    #1;
    check_eq("bp_beat4", BusAdr, {26'h0ABC_DEF, 6'h20});
    drain(26'h0);

    // Full and wrap: fifth push held off until the first pop completes.
    for (int i = 0; i < 4; i++) step(1'b1, 26'h100 + 26'(i), rand_line(), 1'b0, 26'h0);
    #1;
    check_eq("full_ready", EvictReady, 0);
    line = rand_line();
    for (int i = 0; i < 3; i++) step(1'b1, 26'h104, line, 1'b0, 26'h0);
    n = 0;
    while (q.size() == DEPTH && n < 30) begin step(1'b1, 26'h104, line, 1'b1, 26'h0); n++; end
    step(1'b1, 26'h104, line, 1'b1, 26'h0);
    check_eq("wrap_last", q[q.size()-1].adr, 26'h104);
    drain(26'h0);

    // Lookup hit through the last-beat handshake, with an unrelated address as a control.
    step(1'b1, 26'h0001_234, rand_line(), 1'b1, 26'h0001_234);
    drain(26'h0001_234);
    step(1'b1, 26'h0001_234, rand_line(), 1'b1, 26'h0001_235);
    drain(26'h0001_235);

    // Push coinciding with the pop at occupancy 1.
    step(1'b1, 26'h2000, rand_line(), 1'b1, 26'h2000);
    n = 0;
    while (!(active && k == BEATS - 1) && n < 20) begin idle(1'b1, 26'h2001); n++; end
    step(1'b1, 26'h2001, rand_line(), 1'b1, 26'h2001);
    #1;
    check_eq("pp_first", BusFirst, 1);
    check_eq("pp_adr", BusAdr, {26'h2001, 6'h0});
    drain(26'h2001);

    // Reset mid-burst with three entries.
    for (int i = 0; i < 3; i++) step(1'b1, 26'h300 + 26'(i), rand_line(), 1'b0, 26'h0);
    n = 0;
    while (!(active && k == 5) && n < 20) begin idle(1'b1, 26'h300); n++; end
    do_reset(26'h301);
    step(1'b1, 26'h3AA, rand_line(), 1'b1, 26'h3AA);
    idle(1'b1, 26'h3AA);
    #1;
    check_eq("post_rst_first", BusFirst, 1);
    drain(26'h3AA);

    // Random traffic over a small address pool so lookups hit often.
    for (int i = 0; i < 600; i++) begin
      a = 26'h1234 + 26'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), a, rand_line(), $urandom_range(0, 9) < 7,
           26'h1234 + 26'($urandom_range(0, 7)));
    end
    drain(26'h1234);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
